multicycle_ctrl: RTL and testbench



---
 rtl/mctrl_pkg.sv | 46 ++++
 rtl/mctrl_alu_dec.sv | 49 ++++
 rtl/multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle CPU sequencing controller.
package mctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;
    localparam logic [1:0] SRCB_INC = 2'd2;

    localparam logic [1:0] IMM_DP  = 2'd0;
    localparam logic [1:0] IMM_MEM = 2'd1;
    localparam logic [1:0] IMM_BR  = 2'd2;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_TST = 4'b1000;

endpackage

// File: rtl/mctrl_alu_dec.sv
// ALU operation / flag-write decode for data-processing commands.
module mctrl_alu_dec
    import mctrl_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s_bit,
    input  logic       in_exec,
    output logic [2:0] alu_control,
    output logic [1:0] flag_w,
    output logic       no_wb,
    output logic       illegal
);

    logic [2:0] dec_ctrl;
    logic       force_flags;
    logic       arith;
    logic       wr_flags;

    always_comb begin
        dec_ctrl    = ALU_ADD;
        no_wb       = 1'b0;
        illegal     = 1'b0;
        force_flags = 1'b0;
        case (cmd)
            CMD_ADD: dec_ctrl = ALU_ADD;
            CMD_SUB: dec_ctrl = ALU_SUB;
            CMD_AND: dec_ctrl = ALU_AND;
            CMD_ORR: dec_ctrl = ALU_ORR;
            CMD_CMP: begin
                dec_ctrl    = ALU_SUB;
                no_wb       = 1'b1;
                force_flags = 1'b1;
            end
            CMD_TST: begin
                dec_ctrl    = ALU_AND;
                no_wb       = 1'b1;
                force_flags = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Carry/overflow only make sense for add/sub; compares always set flags.
    assign arith       = (dec_ctrl == ALU_ADD) || (dec_ctrl == ALU_SUB);
    assign wr_flags    = s_bit | force_flags;
    assign alu_control = in_exec ? dec_ctrl : ALU_ADD;
    assign flag_w      = in_exec ? {wr_flags, wr_flags & arith} : 2'b00;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multicycle CPU (shared ALU, unified memory).
// Optional performance counters are built when MCTRL_PERF_EN is defined.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int PC_INC     = 4,
    parameter bit ILL_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_w,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_w,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [2:0] alu_control,
    output logic [1:0] flag_w,
    output logic       halted,
    output logic [3:0] state_dbg
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] retired,
    output logic [31:0] stall_cyc
`endif
);

    // The increment constant itself lives in the datapath; only its mux leg is chosen here.
    localparam logic [1:0] INC_SEL = (PC_INC != 0) ? SRCB_INC : SRCB_REG;

    state_t     state, state_next;
    logic       in_exec;
    logic [2:0] dec_alu_control;
    logic [1:0] dec_flag_w;
    logic       dec_no_wb;
    logic       dec_illegal;
    logic [1:0] op_imm_src;
    logic [1:0] op_reg_src;
    state_t     ill_next;

    assign in_exec  = (state == EXEC_R) || (state == EXEC_I);
    assign ill_next = ILL_STICKY ? HALT : FETCH;

    mctrl_alu_dec u_alu_dec (
        .cmd         (funct[4:1]),
        .s_bit       (funct[0]),
        .in_exec     (in_exec),
        .alu_control (dec_alu_control),
        .flag_w      (dec_flag_w),
        .no_wb       (dec_no_wb),
        .illegal     (dec_illegal)
    );

    always_comb begin
        op_imm_src = IMM_DP;
        op_reg_src = 2'b00;
        case (op)
            OP_MEM: begin
                op_imm_src    = IMM_MEM;
                op_reg_src[1] = ~funct[0];
            end
            OP_BR: begin
                op_imm_src    = IMM_BR;
                op_reg_src[0] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // Outputs are held at their idle values while reset is asserted so an
    // in-flight memory write or register update is dropped immediately.
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_w       = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_w       = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        imm_src     = IMM_DP;
        reg_src     = 2'b00;
        alu_control = ALU_ADD;
        flag_w      = 2'b00;
        halted      = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = INC_SEL;
                    result_src = RES_ALU;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = INC_SEL;
                    imm_src   = op_imm_src;
                    reg_src   = op_reg_src;
                    if (!cond_ex) begin
                        state_next = FETCH;
                    end else begin
                        case (op)
                            OP_MEM:  state_next = MEMADR;
                            OP_BR:   state_next = BRANCH;
                            OP_DP:   state_next = dec_illegal ? ill_next :
                                                  (funct[5] ? EXEC_I : EXEC_R);
                            default: state_next = ill_next;
                        endcase
                    end
                end
                MEMADR: begin
                    alu_src_b  = SRCB_IMM;
                    imm_src    = op_imm_src;
                    reg_src    = op_reg_src;
                    state_next = funct[0] ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_next = MEMWB;
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_w      = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    mem_req = 1'b1;
                    mem_w   = 1'b1;
                    adr_src = 1'b1;
                    reg_src = op_reg_src;
                    if (mem_ready) state_next = FETCH;
                end
                EXEC_R, EXEC_I: begin
                    alu_src_b   = (state == EXEC_I) ? SRCB_IMM : SRCB_REG;
                    imm_src     = op_imm_src;
                    alu_control = dec_alu_control;
                    flag_w      = dec_flag_w;
                    state_next  = dec_no_wb ? FETCH : ALUWB;
                end
                ALUWB: begin
                    result_src = RES_ALUOUT;
                    reg_w      = 1'b1;
                    pc_write   = (rd == 4'd15);
                    state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = op_imm_src;
                    reg_src    = op_reg_src;
                    result_src = RES_ALU;
                    pc_write   = 1'b1;
                    state_next = FETCH;
                end
                HALT: halted = 1'b1;
                default: state_next = FETCH;
            endcase
        end
    end

    assign state_dbg = state;

`ifdef MCTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired   <= 32'd0;
            stall_cyc <= 32'd0;
        end else begin
            if ((state_next == FETCH) && (state != FETCH))
                retired <= retired + 32'd1;
            if (mem_req && !mem_ready)
                stall_cyc <= stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default build).
module tb_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MEMADR = 4'd2;
    localparam logic [3:0] ST_MEMRD  = 4'd3;
    localparam logic [3:0] ST_MEMWB  = 4'd4;
    localparam logic [3:0] ST_MEMWR  = 4'd5;
    localparam logic [3:0] ST_EXEC_R = 4'd6;
    localparam logic [3:0] ST_EXEC_I = 4'd7;
    localparam logic [3:0] ST_ALUWB  = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_HALT   = 4'd10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex;
    logic       mem_ready;
    logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, imm_src, reg_src;
    logic [2:0] alu_control;
    logic [1:0] flag_w;
    logic       halted;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .cond_ex     (cond_ex),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_w       (mem_w),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_w       (reg_w),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .alu_control (alu_control),
        .flag_w      (flag_w),
        .halted      (halted),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; op = 2'b00; funct = 6'd0; rd = 4'd0; cond_ex = 1'b1; mem_ready = 1'b1;
        #3;
        check("rst_state", 32'(state_dbg), 32'(ST_FETCH));
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_ir_write", 32'(ir_write), 0);
        check("rst_pc_write", 32'(pc_write), 0);
        check("rst_reg_w", 32'(reg_w), 0);
        check("rst_flag_w", 32'(flag_w), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_alu_src_b", 32'(alu_src_b), 0);
        check("rst_result_src", 32'(result_src), 0);

        // ADD R1,R2,R3
        @(posedge clk);
        #2;
        rst_n = 1'b1; op = 2'b00; funct = 6'b001000; rd = 4'd1;
        #1;
        check("fetch_mem_req", 32'(mem_req), 1);
        check("fetch_adr_src", 32'(adr_src), 0);
        check("fetch_ir_write", 32'(ir_write), 1);
        check("fetch_pc_write", 32'(pc_write), 1);
        check("fetch_alu_src_a", 32'(alu_src_a), 1);
        check("fetch_alu_src_b", 32'(alu_src_b), 2);
        check("fetch_result_src", 32'(result_src), 2);
        check("fetch_alu_control", 32'(alu_control), 0);
        tick();
        check("add_decode", 32'(state_dbg), 32'(ST_DECODE));
        check("add_decode_reg_w", 32'(reg_w), 0);
        check("add_decode_src_b", 32'(alu_src_b), 2);
        tick();
        check("add_exec", 32'(state_dbg), 32'(ST_EXEC_R));
        check("add_exec_src_b", 32'(alu_src_b), 0);
        check("add_exec_alu", 32'(alu_control), 0);
        check("add_exec_flag_w", 32'(flag_w), 0);
        check("add_exec_reg_w", 32'(reg_w), 0);
        tick();
        check("add_aluwb", 32'(state_dbg), 32'(ST_ALUWB));
        check("add_aluwb_reg_w", 32'(reg_w), 1);
        check("add_aluwb_result_src", 32'(result_src), 0);
        check("add_aluwb_pc_write", 32'(pc_write), 0);

        // LDR with three stall cycles in MEMRD
        op = 2'b01; funct = 6'b011001; rd = 4'd2;
        tick();
        check("ldr_fetch", 32'(state_dbg), 32'(ST_FETCH));
        tick();
        check("ldr_decode_imm_src", 32'(imm_src), 1);
        check("ldr_decode_reg_src", 32'(reg_src), 0);
        tick();
        check("ldr_memadr", 32'(state_dbg), 32'(ST_MEMADR));
        check("ldr_memadr_src_a", 32'(alu_src_a), 0);
        check("ldr_memadr_src_b", 32'(alu_src_b), 1);
        check("ldr_memadr_mem_req", 32'(mem_req), 0);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("ldr_stall_state", 32'(state_dbg), 32'(ST_MEMRD));
            check("ldr_stall_mem_req", 32'(mem_req), 1);
            check("ldr_stall_adr_src", 32'(adr_src), 1);
            check("ldr_stall_mem_w", 32'(mem_w), 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("ldr_ready_state", 32'(state_dbg), 32'(ST_MEMRD));
        check("ldr_ready_mem_req", 32'(mem_req), 1);
        check("ldr_ready_adr_src", 32'(adr_src), 1);
        tick();
        check("ldr_memwb", 32'(state_dbg), 32'(ST_MEMWB));
        check("ldr_memwb_reg_w", 32'(reg_w), 1);
        check("ldr_memwb_result_src", 32'(result_src), 1);
        check("ldr_memwb_mem_req", 32'(mem_req), 0);

        // CMP (SUBS-style compare, no writeback)
        op = 2'b00; funct = 6'b010101; rd = 4'd0;
        tick();
        check("cmp_fetch", 32'(state_dbg), 32'(ST_FETCH));
        tick();
        tick();
        check("cmp_exec", 32'(state_dbg), 32'(ST_EXEC_R));
        check("cmp_flag_w", 32'(flag_w), 3);
        check("cmp_alu", 32'(alu_control), 1);
        tick();
        check("cmp_no_aluwb", 32'(state_dbg), 32'(ST_FETCH));

        // Branch squashed by condition, then taken
        op = 2'b10; funct = 6'd0; cond_ex = 1'b0;
        #1;
        check("br_fetch_pc_write", 32'(pc_write), 1);
        tick();
        check("br_sq_decode", 32'(state_dbg), 32'(ST_DECODE));
        check("br_sq_pc_write", 32'(pc_write), 0);
        check("br_decode_imm_src", 32'(imm_src), 2);
        check("br_decode_reg_src", 32'(reg_src), 1);
        tick();
        check("br_sq_fetch", 32'(state_dbg), 32'(ST_FETCH));
        cond_ex = 1'b1;
        tick();
        tick();
        check("br_branch", 32'(state_dbg), 32'(ST_BRANCH));
        check("br_pc_write", 32'(pc_write), 1);
        check("br_src_a", 32'(alu_src_a), 1);
        check("br_src_b", 32'(alu_src_b), 1);
        check("br_result_src", 32'(result_src), 2);
        check("br_reg_w", 32'(reg_w), 0);

        // ORR immediate with Rd = R15
        op = 2'b00; funct = 6'b111000; rd = 4'd15;
        tick();
        tick();
        tick();
        check("orr_exec_i", 32'(state_dbg), 32'(ST_EXEC_I));
        check("orr_src_b", 32'(alu_src_b), 1);
        check("orr_alu", 32'(alu_control), 3);
        check("orr_flag_w", 32'(flag_w), 0);
        tick();
        check("orr_aluwb", 32'(state_dbg), 32'(ST_ALUWB));
        check("orr_pc_write", 32'(pc_write), 1);
        check("orr_reg_w", 32'(reg_w), 1);

        // op=11 parks in HALT
        op = 2'b11; funct = 6'd0; rd = 4'd0;
        tick();
        tick();
        tick();
        check("ill_halt", 32'(state_dbg), 32'(ST_HALT));
        check("ill_halted", 32'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            check("halt_enables", 32'({mem_req, mem_w, ir_write, pc_write, reg_w, flag_w}), 0);
            check("halt_state", 32'(state_dbg), 32'(ST_HALT));
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("halt_rst_state", 32'(state_dbg), 32'(ST_FETCH));
        check("halt_rst_halted", 32'(halted), 0);
        tick();
        rst_n = 1'b1; op = 2'b01; funct = 6'b011000; rd = 4'd3;
        #1;
        check("post_rst_fetch", 32'(state_dbg), 32'(ST_FETCH));
        check("post_rst_mem_req", 32'(mem_req), 1);

        // STR stalled in MEMWR, then aborted by reset
        tick();
        check("str_decode_reg_src", 32'(reg_src), 2);
        mem_ready = 1'b0;
        tick();
        tick();
        check("str_memwr", 32'(state_dbg), 32'(ST_MEMWR));
        check("str_mem_req", 32'(mem_req), 1);
        check("str_mem_w", 32'(mem_w), 1);
        check("str_adr_src", 32'(adr_src), 1);
        tick();
        check("str_hold", 32'(state_dbg), 32'(ST_MEMWR));
        check("str_hold_mem_w", 32'(mem_w), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 0);
        check("abort_mem_w", 32'(mem_w), 0);
        check("abort_adr_src", 32'(adr_src), 0);
        check("abort_state", 32'(state_dbg), 32'(ST_FETCH));

        // Unsupported data-processing command also halts
        tick();
        rst_n = 1'b1; mem_ready = 1'b1; op = 2'b00; funct = 6'b000110;
        tick();
        check("badcmd_decode", 32'(state_dbg), 32'(ST_DECODE));
        tick();
        check("badcmd_halt", 32'(state_dbg), 32'(ST_HALT));
        check("badcmd_halted", 32'(halted), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
